// File: rtl/alu_seq.sv
// alu_seq: command-side sequencer for the 32-bit ALU datapath.
// Accepts one command at a time over a valid/ready channel, steers the external
// ALU (alu_op/alu_a/alu_b), consumes alu_r/alu_flags and returns a registered
// response (rsp_data/rsp_flags/rsp_err) over a valid/ready channel.
// Codes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 BEQ, 7 BNE, 8 BLT, 9 BGE,
//        10 MUL (only when ALU_SEQ_MUL_EN is defined), 11-15 illegal.
// Build option: define ALU_SEQ_MUL_EN to build the shift-add multiplier
// (MUL state, accumulator, iteration counter); otherwise code 10 is illegal.
// Ports:
//   clk, rst_n                        clock, async active-low reset
//   cmd_valid/cmd_ready/cmd_code/a/b  command channel
//   rsp_valid/rsp_ready/rsp_data/flags/err  response channel
//   alu_op/alu_a/alu_b                datapath controls (combinational from state)
//   alu_flags/alu_r                   datapath results
module alu_seq #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned MUL_ITERS = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_code,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic [3:0]       rsp_flags,
    output logic             rsp_err,
    output logic [2:0]       alu_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [3:0]       alu_flags,
    input  logic [WIDTH-1:0] alu_r
);

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
`ifdef ALU_SEQ_MUL_EN
        , MUL = 2'd3
`endif
    } stateT;

    stateT            state;
    logic [3:0]       codeQ;
    logic [WIDTH-1:0] aQ;      // operand A; doubles as the shifting multiplicand
    logic [WIDTH-1:0] bQ;      // operand B; doubles as the shifting multiplier

`ifdef ALU_SEQ_MUL_EN
    localparam logic [3:0]  CODE_MUL = 4'd10;
    localparam int unsigned CNT_W    = (MUL_ITERS > 1) ? $clog2(MUL_ITERS) : 1;
    logic [WIDTH-1:0] acc;
    logic [CNT_W-1:0] count;
`endif

    logic [WIDTH-1:0] execData;
    logic             execErr;

    // Datapath steering: only EXEC (legal codes) and MUL drive the ALU.
    always_comb begin
        alu_op = '0;
        alu_a  = '0;
        alu_b  = '0;
        case (state)
            EXEC: begin
                if (codeQ <= 4'd4) begin
                    alu_op = codeQ[2:0];
                    alu_a  = aQ;
                    alu_b  = bQ;
                end else if (codeQ <= 4'd9) begin
                    // Compare/branch ops read flags from a subtract.
                    alu_op = ALU_SUB;
                    alu_a  = aQ;
                    alu_b  = bQ;
                end
            end
`ifdef ALU_SEQ_MUL_EN
            MUL: begin
                alu_op = ALU_ADD;
                alu_a  = acc;
                alu_b  = aQ;
            end
`endif
            default: ;
        endcase
    end

    // Result selection for the single-cycle EXEC state.
    always_comb begin
        execData = '0;
        execErr  = 1'b0;
        case (codeQ)
            4'd0, 4'd1, 4'd2, 4'd3, 4'd4: execData = alu_r;
            4'd5, 4'd8:                   execData = WIDTH'(alu_flags[2]);
            4'd6:                         execData = WIDTH'(alu_flags[1]);
            4'd7:                         execData = WIDTH'(alu_flags[0]);
            4'd9:                         execData = WIDTH'(!alu_flags[2]);
            default:                      execErr  = 1'b1;
        endcase
    end

    // Sequencer FSM with registered handshake and response outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cmd_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_flags <= '0;
            rsp_err   <= 1'b0;
            codeQ     <= '0;
            aQ        <= '0;
            bQ        <= '0;
`ifdef ALU_SEQ_MUL_EN
            acc       <= '0;
            count     <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        codeQ     <= cmd_code;
                        aQ        <= cmd_a;
                        bQ        <= cmd_b;
                        cmd_ready <= 1'b0;
                        state     <= EXEC;
`ifdef ALU_SEQ_MUL_EN
                        if (cmd_code == CODE_MUL) begin
                            acc   <= '0;
                            count <= '0;
                            state <= MUL;
                        end
`endif
                    end
                end
                EXEC: begin
                    rsp_data  <= execData;
                    rsp_flags <= execErr ? 4'b0 : alu_flags;
                    rsp_err   <= execErr;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
`ifdef ALU_SEQ_MUL_EN
                MUL: begin
                    if (bQ[0]) begin
                        acc <= alu_r;
                    end
                    aQ    <= aQ << 1;
                    bQ    <= bQ >> 1;
                    count <= count + CNT_W'(1);
                    // Finish once no multiplier bits remain or the budget is spent.
                    if ((bQ[WIDTH-1:1] == '0) || (count == CNT_W'(MUL_ITERS - 1))) begin
                        rsp_data  <= bQ[0] ? alu_r : acc;
                        rsp_flags <= '0;
                        rsp_err   <= 1'b0;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end
                end
`endif
                RESP: begin
                    if (rsp_valid && rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    cmd_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed bench for alu_seq with a behavioural ALU datapath model.
module tb_alu_seq;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_code;
    logic [31:0] cmd_a;
    logic [31:0] cmd_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic [3:0]  rsp_flags;
    logic        rsp_err;
    logic [2:0]  alu_op;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_flags;
    logic [31:0] alu_r;

    int checks = 0;
    int errors = 0;

    alu_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_code  (cmd_code),
        .cmd_a     (cmd_a),
        .cmd_b     (cmd_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_flags (rsp_flags),
        .rsp_err   (rsp_err),
        .alu_op    (alu_op),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_flags (alu_flags),
        .alu_r     (alu_r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Datapath model: result by op, flags from signed comparison of A and B.
    always_comb begin
        case (alu_op)
            3'd0:    alu_r = alu_a + alu_b;
            3'd1:    alu_r = alu_a - alu_b;
            3'd2:    alu_r = alu_a & alu_b;
            3'd3:    alu_r = alu_a | alu_b;
            3'd4:    alu_r = alu_a ^ alu_b;
            default: alu_r = 32'h0;
        endcase
        alu_flags[0] = (alu_a != alu_b);
        alu_flags[1] = (alu_a == alu_b);
        alu_flags[2] = ($signed(alu_a) < $signed(alu_b));
        alu_flags[3] = ($signed(alu_a) > $signed(alu_b));
    end

    // Issue one command and wait for its response. lat counts edges from the
    // accept edge (inclusive) to the edge after which rsp_valid is seen.
    task automatic run_op(input logic [3:0] code, input logic [31:0] a, input logic [31:0] b,
                          input logic rdy, input int maxEdges,
                          output logic [31:0] data, output logic [3:0] flags, output logic err,
                          output int lat, output logic timedOut,
                          output logic [2:0] exOp, output logic [31:0] exA, output logic [31:0] exB);
        @(negedge clk);
        rsp_ready = rdy;
        cmd_valid = 1'b1;
        cmd_code  = code;
        cmd_a     = a;
        cmd_b     = b;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        cmd_valid = 1'b0;
        exOp = alu_op;
        exA  = alu_a;
        exB  = alu_b;
        while (rsp_valid !== 1'b1 && lat < maxEdges) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        timedOut = (rsp_valid !== 1'b1);
        data  = rsp_data;
        flags = rsp_flags;
        err   = rsp_err;
    endtask

    task automatic test_reset;
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_code  = 4'd0;
        cmd_a     = 32'h0;
        cmd_b     = 32'h0;
        rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready got %b exp 1", cmd_ready); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b exp 0", rsp_valid); end
        checks++; if (rsp_data !== 32'h0) begin errors++; $display("FAIL reset_rsp_data got %h exp 0", rsp_data); end
        checks++; if (rsp_flags !== 4'h0) begin errors++; $display("FAIL reset_rsp_flags got %b exp 0", rsp_flags); end
        checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp_err got %b exp 0", rsp_err); end
        checks++; if ({alu_op, alu_a, alu_b} !== 67'h0) begin errors++; $display("FAIL reset_alu got op %0d a %h b %h exp 0", alu_op, alu_a, alu_b); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_arith;
        logic [31:0] d; logic [3:0] f; logic e; int lat; logic to;
        logic [2:0] xo; logic [31:0] xa; logic [31:0] xb;
        run_op(4'd0, 32'd5, 32'd7, 1'b1, 10, d, f, e, lat, to, xo, xa, xb);
        checks++; if (to || lat != 2) begin errors++; $display("FAIL add_latency got %0d exp 2", lat); end
        checks++; if (d !== 32'd12) begin errors++; $display("FAIL add_data got %h exp 0000000c", d); end
        checks++; if (f !== 4'b0101) begin errors++; $display("FAIL add_flags got %b exp 0101", f); end
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL add_err got %b exp 0", e); end
        run_op(4'd1, 32'd3, 32'd5, 1'b1, 10, d, f, e, lat, to, xo, xa, xb);
        checks++; if (d !== 32'hFFFF_FFFE) begin errors++; $display("FAIL sub_data got %h exp fffffffe", d); end
        checks++; if (f !== 4'b0101) begin errors++; $display("FAIL sub_flags got %b exp 0101", f); end
        checks++; if (xo !== 3'd1 || xa !== 32'd3 || xb !== 32'd5) begin errors++; $display("FAIL sub_alu_drive got op %0d a %h b %h exp 1 3 5", xo, xa, xb); end
        run_op(4'd3, 32'hF0, 32'h0F, 1'b1, 10, d, f, e, lat, to, xo, xa, xb);
        checks++; if (d !== 32'hFF || f !== 4'b1001) begin errors++; $display("FAIL or_result got %h/%b exp 000000ff/1001", d, f); end
        run_op(4'd4, 32'hFF00, 32'h0FF0, 1'b1, 10, d, f, e, lat, to, xo, xa, xb);
        checks++; if (d !== 32'hF0F0) begin errors++; $display("FAIL xor_data got %h exp 0000f0f0", d); end
    endtask

    task automatic test_branch;
        logic [31:0] d; logic [3:0] f; logic e; int lat; logic to;
        logic [2:0] xo; logic [31:0] xa; logic [31:0] xb;
        run_op(4'd8, 32'hFFFF_FFFF, 32'd1, 1'b1, 10, d, f, e, lat, to, xo, xa, xb);
        checks++; if (d !== 32'd1 || f !== 4'b0101) begin errors++; $display("FAIL blt got %h/%b exp 00000001/0101", d, f); end
        checks++; if (xo !== 3'd1) begin errors++; $display("FAIL blt_alu_op got %0d exp 1", xo); end
        run_op(4'd9, 32'hFFFF_FFFF, 32'd1, 1'b1, 10, d, f, e, lat, to, xo, xa, xb);
        checks++; if (d !== 32'd0) begin errors++; $display("FAIL bge got %h exp 0", d); end
        run_op(4'd6, 32'h55, 32'h55, 1'b1, 10, d, f, e, lat, to, xo, xa, xb);
        checks++; if (d !== 32'd1 || f !== 4'b0010) begin errors++; $display("FAIL beq got %h/%b exp 00000001/0010", d, f); end
        run_op(4'd7, 32'h55, 32'h55, 1'b1, 10, d, f, e, lat, to, xo, xa, xb);
        checks++; if (d !== 32'd0) begin errors++; $display("FAIL bne got %h exp 0", d); end
        run_op(4'd5, 32'd5, 32'd7, 1'b1, 10, d, f, e, lat, to, xo, xa, xb);
        checks++; if (d !== 32'd1) begin errors++; $display("FAIL slt got %h exp 1", d); end
        run_op(4'd5, 32'd7, 32'hFFFF_FFF0, 1'b1, 10, d, f, e, lat, to, xo, xa, xb);
        checks++; if (d !== 32'd0 || f !== 4'b1001) begin errors++; $display("FAIL slt_neg got %h/%b exp 0/1001", d, f); end
    endtask

    task automatic test_mul;
        logic [31:0] d; logic [3:0] f; logic e; int lat; logic to;
        logic [2:0] xo; logic [31:0] xa; logic [31:0] xb;
`ifdef ALU_SEQ_MUL_EN
        run_op(4'd10, 32'h1234, 32'h10, 1'b1, 40, d, f, e, lat, to, xo, xa, xb);
        checks++; if (to || lat != 6) begin errors++; $display("FAIL mul_small_latency got %0d exp 6", lat); end
        checks++; if (d !== 32'h12340 || f !== 4'h0 || e !== 1'b0) begin errors++; $display("FAIL mul_small got %h/%b/%b exp 00012340/0000/0", d, f, e); end
        run_op(4'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 40, d, f, e, lat, to, xo, xa, xb);
        checks++; if (to || lat != 33) begin errors++; $display("FAIL mul_max_latency got %0d exp 33", lat); end
        checks++; if (d !== 32'h1) begin errors++; $display("FAIL mul_max got %h exp 00000001", d); end
        run_op(4'd10, 32'h9999, 32'h0, 1'b1, 40, d, f, e, lat, to, xo, xa, xb);
        checks++; if (to || lat != 2 || d !== 32'h0) begin errors++; $display("FAIL mul_zero got %h lat %0d exp 0 lat 2", d, lat); end
`else
        run_op(4'd10, 32'h1234, 32'h10, 1'b1, 40, d, f, e, lat, to, xo, xa, xb);
        checks++; if (to || e !== 1'b1 || d !== 32'h0 || f !== 4'h0) begin errors++; $display("FAIL mul_disabled got err %b data %h flags %b exp 1/0/0", e, d, f); end
`endif
    endtask

    task automatic test_backpressure;
        logic [31:0] d; logic [3:0] f; logic e; int lat; logic to;
        logic [2:0] xo; logic [31:0] xa; logic [31:0] xb;
        int bad;
        run_op(4'd2, 32'hF0F0, 32'hFF00, 1'b0, 10, d, f, e, lat, to, xo, xa, xb);
        checks++; if (to || d !== 32'hF000 || f !== 4'b0101) begin errors++; $display("FAIL and_data got %h/%b exp 0000f000/0101", d, f); end
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            cmd_valid = i[0];
            cmd_code  = 4'd0;
            cmd_a     = 32'd100 + 32'(i);
            cmd_b     = 32'd1;
            @(negedge clk);
            checks++;
            if (rsp_valid !== 1'b1 || rsp_data !== 32'hF000 || cmd_ready !== 1'b0) begin
                errors++; bad++;
                if (bad < 4) $display("FAIL hold_cycle_%0d got valid %b data %h ready %b exp 1 0000f000 0", i, rsp_valid, rsp_data, cmd_ready);
            end
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin errors++; $display("FAIL release got valid %b ready %b exp 0 1", rsp_valid, cmd_ready); end
    endtask

    task automatic test_illegal;
        logic [31:0] d; logic [3:0] f; logic e; int lat; logic to;
        logic [2:0] xo; logic [31:0] xa; logic [31:0] xb;
        run_op(4'd15, 32'h1, 32'h2, 1'b1, 10, d, f, e, lat, to, xo, xa, xb);
        checks++; if (to || e !== 1'b1 || d !== 32'h0 || f !== 4'h0) begin errors++; $display("FAIL illegal got err %b data %h flags %b exp 1/0/0", e, d, f); end
        checks++; if (xo !== 3'd0 || xa !== 32'h0 || xb !== 32'h0) begin errors++; $display("FAIL illegal_alu got op %0d a %h b %h exp 0", xo, xa, xb); end
        run_op(4'd0, 32'd9, 32'd1, 1'b1, 10, d, f, e, lat, to, xo, xa, xb);
        checks++; if (e !== 1'b0 || d !== 32'd10) begin errors++; $display("FAIL after_illegal got err %b data %h exp 0 0000000a", e, d); end
    endtask

    task automatic test_reset_mid;
        logic [31:0] d; logic [3:0] f; logic e; int lat; logic to;
        logic [2:0] xo; logic [31:0] xa; logic [31:0] xb;
        @(negedge clk);
`ifdef ALU_SEQ_MUL_EN
        rsp_ready = 1'b1;
        cmd_code  = 4'd10;
`else
        rsp_ready = 1'b0;
        cmd_code  = 4'd0;
`endif
        cmd_valid = 1'b1;
        cmd_a     = 32'hFFFF_FFFF;
        cmd_b     = 32'hFFFF_FFFF;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin errors++; $display("FAIL midreset_hs got ready %b valid %b exp 1 0", cmd_ready, rsp_valid); end
        checks++; if (rsp_data !== 32'h0 || rsp_flags !== 4'h0 || rsp_err !== 1'b0) begin errors++; $display("FAIL midreset_rsp got %h/%b/%b exp 0", rsp_data, rsp_flags, rsp_err); end
        checks++; if ({alu_op, alu_a, alu_b} !== 67'h0) begin errors++; $display("FAIL midreset_alu got op %0d a %h b %h exp 0", alu_op, alu_a, alu_b); end
        @(negedge clk);
        rst_n = 1'b1;
        run_op(4'd0, 32'd1, 32'd1, 1'b1, 10, d, f, e, lat, to, xo, xa, xb);
        checks++; if (to || d !== 32'd2 || lat != 2) begin errors++; $display("FAIL post_reset_add got %h lat %0d exp 00000002 lat 2", d, lat); end
    endtask

    task automatic test_back_to_back;
        int handshakes;
        int bad;
        handshakes = 0;
        bad = 0;
        @(negedge clk);
        rsp_ready = 1'b1;
        cmd_valid = 1'b1;
        cmd_code  = 4'd0;
        cmd_a     = 32'd2;
        cmd_b     = 32'd3;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) begin
                handshakes++;
                checks++;
                if (rsp_data !== 32'd5) begin errors++; bad++; if (bad < 4) $display("FAIL b2b_data got %h exp 00000005", rsp_data); end
            end
        end
        cmd_valid = 1'b0;
        checks++; if (handshakes != 4) begin errors++; $display("FAIL b2b_throughput got %0d exp 4", handshakes); end
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        test_reset;
        test_arith;
        test_branch;
        test_mul;
        test_backpressure;
        test_illegal;
        test_back_to_back;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
